led_frame_rx: RTL and testbench
===============================

LED_FRAME_RX -- requirements
Module: led_frame_rx

Interface
REQ-001 Parameter NUM_LED, default 360, number of LED words per frame.
REQ-002 Parameter DATA_W, default 16, width of one LED brightness word.
REQ-003 Parameter ADDR_W, default 10, width of the write-address bus.
REQ-004 Parameter TIMEOUT, default 1023, cycles allowed without capture progress before the frame is dropped.
REQ-005 clk  in  1  single system clock (25 MHz dclk domain); all logic is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 sdbpflag  in  1  frame-start strobe from the frame writer; a level that holds high for several cycles.
REQ-008 wtaddr  in  ADDR_W  writer address; holds at 0 before a frame, then steps 1..NUM_LED.
REQ-009 wtdina  in  DATA_W  writer data; the value on wtdina in cycle t belongs to the wtaddr value of cycle t-1.
REQ-010 rd_addr  in  9  display-bank read address from the downstream LED scanner.
REQ-011 rd_data  out  DATA_W  display-bank word, registered.
REQ-012 frame_done  out  1  one-cycle pulse when a complete frame is committed.
REQ-013 frame_err  out  1  one-cycle pulse when a frame is aborted.
REQ-014 busy  out  1  high in ARMED or CAPTURE.
REQ-015 bank_sel  out  1  index of the bank currently presented to the display.
REQ-016 frame_cnt  out  16  count of committed frames; wraps at 65535 -> 0.

Function
REQ-017 Storage: two banks of NUM_LED x DATA_W words. The write bank is always ~bank_sel.
REQ-018 Start detection: sdbp_d is sdbpflag registered. A rise is sdbpflag & ~sdbp_d. Only rising edges start a frame.
REQ-019 Alignment: addr_d is wtaddr registered. A write in cycle t stores wtdina into location addr_d.
REQ-020 FSM states and transitions:
  - IDLE -> ARMED on a rise.
  - ARMED -> CAPTURE on the first cycle with wtaddr==0; the capture index idx is cleared to 0.
  - CAPTURE -> COMMIT when idx reaches NUM_LED.
  - COMMIT -> IDLE after one cycle.
REQ-021 CAPTURE data rules:
  - addr_d==idx: write the word, then idx++.
  - addr_d==idx-1 (idx>0): overwrite that location (last value wins), idx unchanged.
  - Any other value: abort.
REQ-022 COMMIT: toggle bank_sel, increment frame_cnt, and pulse frame_done, all in the same cycle.
REQ-023 Abort from ARMED or CAPTURE: pulse frame_err and go to IDLE. bank_sel, frame_cnt and the display bank are unchanged. Abort causes:
  - a rule violation under REQ-021;
  - the progress timer reaching TIMEOUT. The timer clears on entry to ARMED and on every idx increment.
REQ-024 A rise while in ARMED or CAPTURE pulses frame_err and re-enters ARMED in the same transition; the partial frame is discarded.
REQ-025 A rise in the COMMIT cycle is honoured: the FSM goes COMMIT -> ARMED and no frame_err is raised.
REQ-026 Read port:
  - rd_data = display bank word at rd_addr, one cycle after rd_addr is presented.
  - rd_addr >= NUM_LED returns 0.
  - Reads never stall.
  - A bank swap takes effect on the read issued in the cycle after COMMIT.
REQ-027 idx and the timer are saturating-safe at their widths (idx 9 bits, timer 10 bits). No arithmetic wraps inside a frame.

Reset
REQ-028 While rst is high:
  - FSM = IDLE; idx = 0; timer = 0; sdbp_d = 0; addr_d = 0.
  - rd_data = 0, frame_done = 0, frame_err = 0, busy = 0, bank_sel = 0, frame_cnt = 0.
REQ-029 Bank contents are not reset, so reads before the first commit are undefined; the bench shall not check them.
REQ-030 rst asserted mid-CAPTURE discards the frame silently, with no frame_err pulse.

Structure
REQ-031 The shared package holds:
  - NUM_LED, DATA_W, ADDR_W and TIMEOUT defaults;
  - the FSM state enum {IDLE, ARMED, CAPTURE, COMMIT}.
REQ-032 One sub-module, led_frame_bank: a simple dual-port RAM (1 write port, 1 registered read port) instantiated twice, inferable as block RAM.

Verification
REQ-033 Nominal frame: sdbpflag high for 29 cycles; wtaddr held at 0 for 2 cycles, then 1..360; wtdina = 16'h0100+addr.
  - Expect frame_done 1 cycle after idx=360, bank_sel=1 and frame_cnt=1.
  - Expect rd_addr=5 to return 16'h0105 and rd_addr=360 to return 0.
REQ-034 Duplicate address 0: wtdina 16'hAAAA then 16'hBBBB, both while addr_d=0. Expect location 0 = 16'hBBBB.
REQ-035 Gap: wtaddr jumps 10 -> 12. Expect a frame_err pulse, FSM back to IDLE, and bank_sel and frame_cnt unchanged.
REQ-036 Stall: wtaddr frozen at 100 for 1100 cycles. Expect a frame_err pulse after TIMEOUT=1023 cycles without progress.
REQ-037 Restart: a second sdbpflag rise at idx=200. Expect a frame_err pulse and a new capture; the following full frame commits with frame_cnt=1.
REQ-038 Reset: rst pulsed at idx=150. Expect all outputs at reset values, no frame_err, and the next frame captured normally.

Source files
------------

// File: rtl/led_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// led_frame_rx_pkg
// Shared definitions for the LED frame receiver: default geometry of a
// frame, fixed internal counter widths and the receiver FSM state type.
// No ports; imported by led_frame_rx and led_frame_bank.
// ---------------------------------------------------------------------------
package led_frame_rx_pkg;

    // Default frame geometry and progress timeout
    localparam int NUM_LED_DEF = 360;
    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 10;
    localparam int TIMEOUT_DEF = 1023;

    // Fixed internal widths: capture index, progress timer, display read
    // address and committed-frame counter
    localparam int IDX_W     = 9;
    localparam int TIMER_W   = 10;
    localparam int RD_ADDR_W = 9;
    localparam int CNT_W     = 16;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        COMMIT  = 2'd3
    } state_e;

endpackage : led_frame_rx_pkg

// File: rtl/led_frame_bank.sv
// ---------------------------------------------------------------------------
// led_frame_bank
// Simple dual-port RAM holding one frame of LED words: one write port and
// one read port whose output is registered, so it maps onto block RAM.
// Contents are deliberately not reset.
//
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  word at raddr, one cycle after raddr is presented
// ---------------------------------------------------------------------------
module led_frame_bank
    import led_frame_rx_pkg::*;
#(
    parameter int DEPTH  = NUM_LED_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = RD_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Synchronous write and registered read with no reset, which is the
    // shape synthesis recognises as a block RAM.  Out-of-range reads are
    // masked by the owner of this RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule : led_frame_bank

// File: rtl/led_frame_rx.sv
// ---------------------------------------------------------------------------
// led_frame_rx
// Captures a frame of LED brightness words from the frame writer into the
// hidden bank of a double-buffered store, and swaps the banks once the whole
// frame has arrived in order.  Out-of-order or stalled frames are dropped and
// the display bank is left untouched.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   sdbpflag    in   frame-start level from the writer (rising edge starts)
//   wtaddr      in   writer address, 0 before a frame then 1..NUM_LED
//   wtdina      in   writer data, belongs to the previous cycle's wtaddr
//   rd_addr     in   display-bank read address from the LED scanner
//   rd_data     out  display word, one cycle after rd_addr; 0 if out of range
//   frame_done  out  one-cycle pulse when a frame is committed
//   frame_err   out  one-cycle pulse when a frame is aborted
//   busy        out  high while armed or capturing
//   bank_sel    out  bank currently shown to the display
//   frame_cnt   out  committed frame count, wrapping
// ---------------------------------------------------------------------------
module led_frame_rx
    import led_frame_rx_pkg::*;
#(
    parameter int NUM_LED = NUM_LED_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sdbpflag,
    input  logic [ADDR_W-1:0]    wtaddr,
    input  logic [DATA_W-1:0]    wtdina,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 bank_sel,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_LED);
    localparam logic [TIMER_W-1:0]   TIMER_LIM = TIMER_W'(TIMEOUT);
    localparam logic [RD_ADDR_W:0]   RD_LIMIT  = (RD_ADDR_W + 1)'(NUM_LED);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   sdbp_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   bank_sel_q, bank_sel_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   rd_bank_q, rd_bank_d;

    logic                   rise;
    logic                   timed_out;
    logic                   addr_hit;
    logic                   addr_dup;
    logic [IDX_W-1:0]       idx_next;
    logic [TIMER_W-1:0]     timer_inc;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_addr;
    logic [DATA_W-1:0]      rd_bank0, rd_bank1;

    // Frame start is the rising edge of the strobe level only.  The writer
    // data lags its address by one cycle, so the registered address is the
    // one that pairs with wtdina.  idx and the timer saturate instead of
    // wrapping.  A write always lands on addr_q itself: either the next
    // slot or a repeat of the previous one.
    assign rise      = sdbpflag & ~sdbp_q;
    assign timed_out = (timer_q >= TIMER_LIM);
    assign idx_next  = (idx_q == '1) ? idx_q : idx_q + IDX_W'(1);
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
    assign addr_hit  = (addr_q == ADDR_W'(idx_q));
    assign addr_dup  = (idx_q != '0) && (addr_q == ADDR_W'(idx_q - IDX_W'(1)));
    assign wr_addr   = IDX_W'(addr_q);

    // Next-state logic.  A new rise always wins: mid-frame it aborts and
    // re-arms, in COMMIT it re-arms without error while the commit still
    // completes.  In CAPTURE progress clears the timer; a repeated address
    // only overwrites and lets the timer keep running, so a writer stuck
    // on one address still times out.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        bank_sel_d   = bank_sel_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        wr_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                    timer_d = '0;
                end
            end
            ARMED: begin
                if (rise) begin
                    frame_err_d = 1'b1;
                    timer_d     = '0;
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_inc;
                    if (wtaddr == '0) begin
                        state_d = CAPTURE;
                        idx_d   = '0;
                    end
                end
            end
            CAPTURE: begin
                if (rise) begin
                    frame_err_d = 1'b1;
                    state_d     = ARMED;
                    timer_d     = '0;
                end else if (addr_hit) begin
                    wr_en   = 1'b1;
                    idx_d   = idx_next;
                    timer_d = '0;
                    if (idx_next == IDX_LAST) begin
                        state_d = COMMIT;
                    end
                end else if (addr_dup && !timed_out) begin
                    wr_en   = 1'b1;
                    timer_d = timer_inc;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            COMMIT: begin
                bank_sel_d   = ~bank_sel_q;
                frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                frame_done_d = 1'b1;
                if (rise) begin
                    state_d = ARMED;
                    timer_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read side: remember which bank and whether the address was in range
    // when the read was issued, so the swap applies from the next read on.
    always_comb begin
        rd_valid_d = ({1'b0, rd_addr} < RD_LIMIT);
        rd_bank_d  = bank_sel_q;
    end

    // State and output registers with synchronous reset; a reset mid-frame
    // simply drops everything without an error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            sdbp_q       <= 1'b0;
            addr_q       <= '0;
            bank_sel_q   <= 1'b0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_bank_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            sdbp_q       <= sdbpflag;
            addr_q       <= wtaddr;
            bank_sel_q   <= bank_sel_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            rd_valid_q   <= rd_valid_d;
            rd_bank_q    <= rd_bank_d;
        end
    end

    // The write bank is always the one not being displayed.
    led_frame_bank #(
        .DEPTH  (NUM_LED),
        .DATA_W (DATA_W),
        .AW     (RD_ADDR_W)
    ) u_bank0 (
        .clk   (clk),
        .we    (wr_en & bank_sel_q),
        .waddr (wr_addr),
        .wdata (wtdina),
        .raddr (rd_addr),
        .rdata (rd_bank0)
    );

    led_frame_bank #(
        .DEPTH  (NUM_LED),
        .DATA_W (DATA_W),
        .AW     (RD_ADDR_W)
    ) u_bank1 (
        .clk   (clk),
        .we    (wr_en & ~bank_sel_q),
        .waddr (wr_addr),
        .wdata (wtdina),
        .raddr (rd_addr),
        .rdata (rd_bank1)
    );

    assign rd_data    = rd_valid_q ? (rd_bank_q ? rd_bank1 : rd_bank0) : '0;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == ARMED) || (state_q == CAPTURE);
    assign bank_sel   = bank_sel_q;
    assign frame_cnt  = frame_cnt_q;

endmodule : led_frame_rx

// File: tb/tb_led_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_led_frame_rx
// Drives writer-style frames (address sequence plus data lagging one cycle)
// into led_frame_rx and compares the receiver against a frame-level model:
// a committed frame holds, for each location, the data that followed the
// last occurrence of that address; aborted frames leave the display alone.
// ---------------------------------------------------------------------------
module tb_led_frame_rx;

    localparam int NUM_LED = 360;
    localparam int TIMEOUT = 1023;

    logic        clk;
    logic        rst;
    logic        sdbpflag;
    logic [9:0]  wtaddr;
    logic [15:0] wtdina;
    logic [8:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_done;
    logic        frame_err;
    logic        busy;
    logic        bank_sel;
    logic [15:0] frame_cnt;

    led_frame_rx #(
        .NUM_LED (NUM_LED),
        .DATA_W  (16),
        .ADDR_W  (10),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sdbpflag   (sdbpflag),
        .wtaddr     (wtaddr),
        .wtdina     (wtdina),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .bank_sel   (bank_sel),
        .frame_cnt  (frame_cnt)
    );

    // 25 MHz clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_cyc = -1;
    int err_cyc  = -1;
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (frame_err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    // Stimulus frame and frame-level reference model
    int          seq_q[$];
    logic [15:0] dat_q[$];
    logic [15:0] pend     [NUM_LED];
    logic [15:0] exp_disp [NUM_LED];
    logic        exp_bank_sel = 1'b0;
    logic [15:0] exp_cnt      = 16'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writer sequence: `zeros` leading zeros (the first coincides with the
    // strobe rise), then 1..upto with optional random repeats, then a tail
    // of zeros.  Every cycle gets a fresh random data word.
    task automatic buildFrame(input int zeros, input int upto, input int dup_pct,
                              input int tail);
        seq_q.delete();
        dat_q.delete();
        for (int i = 0; i < zeros; i++) seq_q.push_back(0);
        for (int a = 1; a <= upto; a++) begin
            seq_q.push_back(a);
            if (a < NUM_LED && int'($urandom_range(99)) < dup_pct) begin
                repeat ($urandom_range(2, 1)) seq_q.push_back(a);
            end
        end
        for (int i = 0; i < tail; i++) seq_q.push_back(0);
        foreach (seq_q[i]) dat_q.push_back(16'($urandom));
    endtask

    // Drive the sequence one entry per cycle, strobe high for 29 cycles.
    // mark_cyc is the cycle in which mark_addr was first driven.
    task automatic applyStimulus(input int mark_addr, input bit chk_busy,
                                 output int mark_cyc);
        mark_cyc = -1;
        for (int i = 0; i < seq_q.size(); i++) begin
            sdbpflag = (i < 29);
            wtaddr   = 10'(seq_q[i]);
            wtdina   = dat_q[i];
            if (seq_q[i] == mark_addr && mark_cyc < 0) mark_cyc = cyc;
            if (chk_busy && i == 50) checkOutput("busy_mid_frame", 32'(busy), 32'd1);
            tick();
        end
        sdbpflag = 1'b0;
        wtaddr   = '0;
    endtask

    // Commit of the frame just driven: last occurrence of each address wins
    task automatic modelCommit();
        for (int i = 0; i + 1 < seq_q.size(); i++) begin
            if (seq_q[i] >= NUM_LED) break;
            pend[seq_q[i]] = dat_q[i + 1];
        end
        exp_disp     = pend;
        exp_bank_sel = ~exp_bank_sel;
        exp_cnt      = exp_cnt + 16'd1;
    endtask

    task automatic readCheck(input string tag, input int a);
        logic [15:0] exp;
        rd_addr = 9'(a);
        tick();
        exp = (a < NUM_LED) ? exp_disp[a] : 16'h0000;
        checkOutput(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic randomReads(input string tag, input int n);
        for (int k = 0; k < n; k++) readCheck(tag, int'($urandom_range(NUM_LED - 1)));
        readCheck(tag, int'($urandom_range(511, NUM_LED)));
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_bank_sel"}, 32'(bank_sel), 32'(exp_bank_sel));
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_bank_sel"}, 32'(bank_sel), 32'd0);
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        int mark;
        int lat;

        rst      = 1'b1;
        sdbpflag = 1'b0;
        wtaddr   = '0;
        wtdina   = '0;
        rd_addr  = '0;
        repeat (3) tick();
        checkResetValues("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Nominal frame, data 0x0100 + address
        buildFrame(2, NUM_LED, 0, 4);
        for (int i = 1; i < dat_q.size(); i++) dat_q[i] = 16'h0100 + 16'(seq_q[i - 1]);
        d0 = done_cnt;
        e0 = err_cnt;
        applyStimulus(NUM_LED - 1, 1'b1, mark);
        modelCommit();
        checkOutput("nom_done_pulses", 32'(done_cnt - d0), 32'd1);
        checkOutput("nom_err_pulses", 32'(err_cnt - e0), 32'd0);
        checkOutput("nom_done_cycle", 32'(done_cyc), 32'(mark + 3));
        checkStatus("nom");
        readCheck("nom_rd5", 5);
        checkOutput("nom_rd5_const", 32'(rd_data), 32'h0105);
        readCheck("nom_rd360", NUM_LED);
        checkOutput("nom_rd360_const", 32'(rd_data), 32'h0000);
        readCheck("nom_rd359", NUM_LED - 1);
        randomReads("nom_rd_rand", 6);

        // Duplicate address 0 plus random repeats elsewhere
        buildFrame(3, NUM_LED, 10, 4);
        dat_q[2] = 16'hAAAA;
        dat_q[3] = 16'hBBBB;
        d0 = done_cnt;
        e0 = err_cnt;
        applyStimulus(-1, 1'b1, mark);
        modelCommit();
        checkOutput("dup_done_pulses", 32'(done_cnt - d0), 32'd1);
        checkOutput("dup_err_pulses", 32'(err_cnt - e0), 32'd0);
        checkStatus("dup");
        readCheck("dup_rd0", 0);
        checkOutput("dup_rd0_const", 32'(rd_data), 32'hBBBB);
        randomReads("dup_rd_rand", 8);

        // Gap: address jumps 10 -> 12
        buildFrame(2, 10, 0, 0);
        for (int a = 12; a <= 20; a++) seq_q.push_back(a);
        repeat (3) seq_q.push_back(0);
        while (dat_q.size() < seq_q.size()) dat_q.push_back(16'($urandom));
        d0 = done_cnt;
        e0 = err_cnt;
        applyStimulus(-1, 1'b0, mark);
        checkOutput("gap_err_pulses", 32'(err_cnt - e0), 32'd1);
        checkOutput("gap_done_pulses", 32'(done_cnt - d0), 32'd0);
        checkOutput("gap_busy", 32'(busy), 32'd0);
        checkStatus("gap");
        randomReads("gap_rd_rand", 4);

        // Stall: address frozen at 100 for 1100 cycles
        buildFrame(2, 100, 0, 0);
        repeat (1100) seq_q.push_back(100);
        repeat (3) seq_q.push_back(0);
        while (dat_q.size() < seq_q.size()) dat_q.push_back(16'($urandom));
        d0 = done_cnt;
        e0 = err_cnt;
        applyStimulus(100, 1'b1, mark);
        lat = err_cyc - mark;
        checkOutput("stall_err_pulses", 32'(err_cnt - e0), 32'd1);
        checkOutput("stall_latency_in_window",
                    32'((lat >= TIMEOUT) && (lat <= TIMEOUT + 4)), 32'd1);
        checkOutput("stall_done_pulses", 32'(done_cnt - d0), 32'd0);
        checkStatus("stall");
        randomReads("stall_rd_rand", 4);

        // Restart: new rise at idx 200, then a complete frame
        d0 = done_cnt;
        e0 = err_cnt;
        buildFrame(2, 200, 0, 0);
        applyStimulus(-1, 1'b1, mark);
        buildFrame(2, NUM_LED, 5, 4);
        applyStimulus(-1, 1'b0, mark);
        modelCommit();
        checkOutput("restart_err_pulses", 32'(err_cnt - e0), 32'd1);
        checkOutput("restart_done_pulses", 32'(done_cnt - d0), 32'd1);
        checkStatus("restart");
        randomReads("restart_rd_rand", 8);

        // Reset at idx 150, then a complete frame
        e0 = err_cnt;
        buildFrame(2, 150, 0, 0);
        applyStimulus(-1, 1'b1, mark);
        rst = 1'b1;
        repeat (2) tick();
        checkResetValues("midrst");
        rst = 1'b0;
        tick();
        checkOutput("midrst_err_pulses", 32'(err_cnt - e0), 32'd0);
        exp_bank_sel = 1'b0;
        exp_cnt      = 16'd0;
        d0 = done_cnt;
        buildFrame(2, NUM_LED, 5, 4);
        applyStimulus(-1, 1'b1, mark);
        modelCommit();
        checkOutput("postrst_done_pulses", 32'(done_cnt - d0), 32'd1);
        checkStatus("postrst");
        randomReads("postrst_rd_rand", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_frame_rx
